// File: rtl/lenet5_pkg.sv
// Shared lenet5 definitions: writer FSM encoding, default widths
// and a saturating narrow helper used by the layer datapaths.
package lenet5_pkg;

  localparam int FMW_PIXELWIDTH   = 8;
  localparam int FMW_RESULT_WIDTH = 32;

  typedef enum logic [1:0] {
    FMW_IDLE    = 2'd0,
    FMW_CAPTURE = 2'd1,
    FMW_FULL    = 2'd2
  } fmw_state_t;

  // Clamp a sign-extended value into a w-bit signed range.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/fmw_ram.sv
// Frame store: one write port, one registered read port.
// Reads in the same cycle as a write to that address see old data.
module fmw_ram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;

  assign in_range = 32'(raddr) < 32'(DEPTH);

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  // Registered read, holds when idle, zero outside the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (re)
      rdata <= in_range ? mem[raddr] : '0;
  end

endmodule

// File: rtl/feature_map_writer.sv
// Captures one raster frame of layer results into a local RAM.
// Optional FMW_CLAMP_EN saturates values instead of truncating.
module feature_map_writer
  import lenet5_pkg::*;
#(
  parameter int NUMPIXELS  = 1024,
  parameter int IMAGE_COLS = 32,
  parameter int IN_WIDTH   = FMW_RESULT_WIDTH,
  parameter int PIXELWIDTH = FMW_PIXELWIDTH,
  localparam int ADDR_W    = $clog2(NUMPIXELS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [IN_WIDTH-1:0] in_data,
  output logic                       in_ready,
  input  logic                       release_frame,
  output logic                       frame_done,
  output logic                       frame_full,
  output logic [ADDR_W-1:0]          wr_col,
  output logic [ADDR_W-1:0]          wr_row,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [PIXELWIDTH-1:0]      rd_data,
  output logic [15:0]                sat_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUMPIXELS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMAGE_COLS - 1);

  fmw_state_t                state;
  fmw_state_t                next;
  logic [ADDR_W-1:0]         addr;
  logic [PIXELWIDTH-1:0]     pixel;
  logic                      xfer;
  logic                      last;
  logic                      rearm;

  assign xfer  = in_valid & in_ready;
  assign last  = addr == LAST_ADDR;
  assign rearm = (state == FMW_FULL) & release_frame;

`ifdef FMW_CLAMP_EN
  logic signed [63:0] wide;
  logic signed [63:0] sat;
  logic               clamped;

  assign wide    = 64'(in_data);
  assign sat     = saturate(wide, PIXELWIDTH);
  assign pixel   = sat[PIXELWIDTH-1:0];
  assign clamped = sat != wide;

  // Count clamped beats for this frame, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_count <= '0;
    else if (rearm)
      sat_count <= '0;
    else if (xfer && clamped && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`else
  logic unused_in;

  assign unused_in = ^in_data;
  assign pixel     = in_data[PIXELWIDTH-1:0];
  assign sat_count = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= FMW_IDLE;
    else
      state <= next;
  end

  // Next-state: start on a beat, fill on the last one, rearm on release.
  always_comb begin
    next = state;
    unique case (state)
      FMW_IDLE:
        if (xfer)
          next = last ? FMW_FULL : FMW_CAPTURE;
      FMW_CAPTURE:
        if (xfer && last)
          next = FMW_FULL;
      FMW_FULL:
        if (release_frame)
          next = FMW_IDLE;
      default:
        next = FMW_IDLE;
    endcase
  end

  // Handshake outputs; ready stays low while reset is held.
  always_comb begin
    in_ready   = 1'b0;
    frame_full = 1'b0;
    unique case (state)
      FMW_IDLE,
      FMW_CAPTURE:
        in_ready = ~rst;
      FMW_FULL:
        frame_full = 1'b1;
      default: begin
        in_ready   = 1'b0;
        frame_full = 1'b0;
      end
    endcase
  end

  // Write address plus raster column/row tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      wr_col <= '0;
      wr_row <= '0;
    end else if (rearm) begin
      addr   <= '0;
      wr_col <= '0;
      wr_row <= '0;
    end else if (xfer) begin
      if (last) begin
        addr   <= '0;
        wr_col <= '0;
        wr_row <= '0;
      end else begin
        addr <= addr + 1'b1;
        if (wr_col == LAST_COL) begin
          wr_col <= '0;
          wr_row <= wr_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
    end
  end

  // One-cycle pulse on the first cycle holding a full frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_done <= 1'b0;
    else
      frame_done <= xfer & last;
  end

  fmw_ram #(
    .DEPTH  (NUMPIXELS),
    .WIDTH  (PIXELWIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (xfer),
    .waddr (addr),
    .wdata (pixel),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_feature_map_writer.sv
// Randomised bench for feature_map_writer against a frame-level model.
// Builds with or without FMW_CLAMP_EN to match the design.
module tb_feature_map_writer;

  localparam int N    = 1024;
  localparam int COLS = 32;
  localparam int AW   = 10;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic signed [31:0] in_data;
  logic              in_ready;
  logic              release_frame;
  logic              frame_done;
  logic              frame_full;
  logic [AW-1:0]     wr_col;
  logic [AW-1:0]     wr_row;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [7:0]        rd_data;
  logic [15:0]       sat_count;

  feature_map_writer #(
    .NUMPIXELS  (N),
    .IMAGE_COLS (COLS),
    .IN_WIDTH   (32),
    .PIXELWIDTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .release_frame (release_frame),
    .frame_done    (frame_done),
    .frame_full    (frame_full),
    .wr_col        (wr_col),
    .wr_row        (wr_row),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .sat_count     (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_pulses = 0;

  // Model state: frame contents, beats in frame, full flag.
  logic [7:0] m_mem [N];
  bit         m_known [N];
  int         m_cnt;
  bit         m_full;
  bit         m_done;
  logic [7:0] m_rd;
  bit         m_rd_known;
  int         m_sat;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack(input logic signed [31:0] v);
`ifdef FMW_CLAMP_EN
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
`endif
    return v[7:0];
  endfunction

  function automatic bit clamps(input logic signed [31:0] v);
`ifdef FMW_CLAMP_EN
    return (v > 127) || (v < -128);
`else
    return (v != v);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_full = 0; m_done = 0;
      m_rd = 8'h00; m_rd_known = 1; m_sat = 0;
    end else begin
      bit xfer;
      xfer = in_valid && !m_full;
      if (rd_en) begin
        if (int'(rd_addr) < N) begin
          m_rd = m_mem[rd_addr];
          m_rd_known = m_known[rd_addr];
        end else begin
          m_rd = 8'h00;
          m_rd_known = 1;
        end
      end
      m_done = 0;
      if (m_full && release_frame) begin
        m_full = 0; m_cnt = 0; m_sat = 0;
      end else if (xfer) begin
        m_mem[m_cnt] = pack(in_data);
        m_known[m_cnt] = 1;
        if (clamps(in_data) && m_sat != 16'hFFFF) m_sat++;
        if (m_cnt == N - 1) begin
          m_full = 1; m_done = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, (!m_full && !rst));
    chk("frame_full", frame_full, m_full);
    chk("frame_done", frame_done, m_done);
    chk("wr_col", wr_col, m_cnt % COLS);
    chk("wr_row", wr_row, m_cnt / COLS);
    chk("sat_count", sat_count, m_sat);
    if (m_rd_known) chk("rd_data", rd_data, m_rd);
    if (frame_done === 1'b1) done_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; release_frame = 0; rd_en = 0;
  endtask

  // mode 0: data = raster index, 1: any 32-bit, 2: small signed
  task automatic stream(input int n, input int mode, input bit gaps);
    int sent = 0;
    int budget = 0;
    bit acc;
    while (sent < n && budget < 20 * n + 100) begin
      in_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
      case (mode)
        0: in_data = m_cnt;
        1: in_data = $urandom;
        default: in_data = int'($urandom_range(0, 800)) - 400;
      endcase
      rd_en = $urandom % 2;
      rd_addr = AW'($urandom % N);
      release_frame = ($urandom % 8 == 0);
      acc = in_valid && !m_full;
      step();
      if (acc) sent++;
      budget++;
    end
    if (sent < n) chk("stream_timeout", sent, n);
    quiet();
  endtask

  task automatic read(input int a, output logic [7:0] d);
    rd_en = 1; rd_addr = AW'(a);
    step();
    d = rd_data;
    rd_en = 0;
  endtask

  task automatic release_pulse();
    release_frame = 1;
    step();
    release_frame = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    for (int i = 0; i < N; i++) m_known[i] = 0;
    in_valid = 0; in_data = 0; release_frame = 0;
    rd_en = 0; rd_addr = '0;
    rst = 1;
    repeat (3) step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_wr_row", wr_row, 0);
    rst = 0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    step();

    // Full frame of raster indices, valid held high.
    done_pulses = 0;
    stream(N, 0, 0);
    in_valid = 1; in_data = 32'hAA;
    repeat (4) step();
    in_valid = 0;
    chk("t1_full", frame_full, 1);
    chk("t1_done_once", done_pulses, 1);
    read(3, d);    chk("t1_rd3", d, 8'h03);
`ifdef FMW_CLAMP_EN
    read(200, d);  chk("t1_rd200", d, 8'h7F);
    read(1023, d); chk("t1_rd1023", d, 8'h7F);
`else
    read(200, d);  chk("t1_rd200", d, 8'hC8);
    read(1023, d); chk("t1_rd1023", d, 8'hFF);
`endif
    read(0, d);    chk("t3_no_write_full", d, 8'h00);

    // Release with a beat offered in the same cycle: not taken.
    in_valid = 1; in_data = 32'hAA;
    release_pulse();
    in_valid = 0;
    chk("t3_rearm_ready", in_ready, 1);
    read(0, d);    chk("t3_release_no_xfer", d, 8'h00);

    // Gappy random frame; raster position after 33 beats.
    stream(33, 1, 1);
    chk("t2_col33", wr_col, 1);
    chk("t2_row33", wr_row, 1);
    stream(N - 33, 1, 1);
    for (int a = 0; a < N; a++) begin
      rd_en = 1; rd_addr = AW'(a);
      step();
    end
    rd_en = 0;
    release_pulse();

    // Reset mid-frame, then a fresh full frame.
    stream(500, 2, 1);
    rst = 1;
    step(); step();
    rst = 0;
    chk("t4_col_after_rst", wr_col, 0);
    chk("t4_full_after_rst", frame_full, 0);
    done_pulses = 0;
    stream(N - 1, 2, 1);
    chk("t4_not_full_1023", frame_full, 0);
    stream(1, 2, 0);
    chk("t4_full_1024", frame_full, 1);
    step();
    chk("t4_done_once", done_pulses, 1);
    release_pulse();

    // Read-before-write on address 5.
    stream(5, 1, 1);
    in_valid = 1; in_data = 32'h11;
    step();
    in_valid = 0;
    stream(N - 6, 1, 1);
    release_pulse();
    stream(5, 1, 1);
    in_valid = 1; in_data = 32'h3C;
    rd_en = 1; rd_addr = AW'(5);
    step();
    in_valid = 0; rd_en = 0;
    chk("t5_old_value", rd_data, 8'h11);
    read(5, d);    chk("t5_new_value", d, 8'h3C);

    // Out-of-range values.
    stream(N - 6, 1, 1);
    release_pulse();
    in_valid = 1; in_data = 300;
    step();
    in_data = -200;
    step();
    in_valid = 0;
`ifdef FMW_CLAMP_EN
    read(0, d); chk("t6_pos", d, 8'h7F);
    read(1, d); chk("t6_neg", d, 8'h80);
    chk("t6_sat", sat_count, 2);
`else
    read(0, d); chk("t6_pos", d, 8'h2C);
    read(1, d); chk("t6_neg", d, 8'h38);
    chk("t6_sat", sat_count, 0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
